// File: rtl/cw305_aes_batch_sched_pkg.sv
// Shared types for the CW305 AES batch sequencer: FSM state encoding and,
// when CW305_BATCH_LFSR_EN is defined, the Galois LFSR step used for text generation.
package cw305_aes_batch_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_FINISH    = 3'd5
    } state_e;

`ifdef CW305_BATCH_LFSR_EN
    localparam logic [127:0] LFSR_POLY = 128'h87;

    function automatic logic [127:0] lfsr_step(input logic [127:0] text);
        lfsr_step = {text[126:0], 1'b0} ^ (text[127] ? LFSR_POLY : 128'h0);
    endfunction
`endif

endpackage

// File: rtl/cw305_aes_batch_sched_textgen.sv
// Combinational next-plaintext generator: chain (last cipher), increment, or
// Galois LFSR step when CW305_BATCH_LFSR_EN is defined.
module cw305_aes_batch_sched_textgen
    import cw305_aes_batch_sched_pkg::*;
#(
    parameter int pPT_WIDTH = 128
) (
    input  logic                 i_chain,
    input  logic [pPT_WIDTH-1:0] i_text,
    input  logic [pPT_WIDTH-1:0] i_cipher,
    output logic [pPT_WIDTH-1:0] o_next
);

    // Next-text selection
    always_comb begin
        o_next = '0;
        if (i_chain) begin
            o_next = i_cipher;
        end else begin
`ifdef CW305_BATCH_LFSR_EN
            o_next = lfsr_step(i_text);
`else
            o_next = i_text + {{(pPT_WIDTH-1){1'b0}}, 1'b1};
`endif
        end
    end

endmodule

// File: rtl/cw305_aes_batch_sched.sv
// Batch sequencer driving the AES core: FSM, gap/iteration counters, done-edge
// detect and capture registers. Optional LFSR text mode: CW305_BATCH_LFSR_EN.
module cw305_aes_batch_sched
    import cw305_aes_batch_sched_pkg::*;
#(
    parameter int pPT_WIDTH  = 128,
    parameter int pCNT_WIDTH = 16,
    parameter int pGAP_WIDTH = 8
) (
    input  logic                  crypto_clk,
    input  logic                  reset_n,
    input  logic                  batch_go,
    input  logic                  batch_abort,
    input  logic [pCNT_WIDTH-1:0] cfg_count,
    input  logic [pGAP_WIDTH-1:0] cfg_gap,
    input  logic                  cfg_chain,
    input  logic [pPT_WIDTH-1:0]  seed_text,
    input  logic                  I_ready,
    input  logic                  I_done,
    input  logic [pPT_WIDTH-1:0]  I_cipherout,
    output logic                  O_start,
    output logic [pPT_WIDTH-1:0]  O_textin,
    output logic                  O_busy,
    output logic                  O_batch_done,
    output logic                  O_aborted,
    output logic [pCNT_WIDTH-1:0] O_iter,
    output logic [pPT_WIDTH-1:0]  O_last_cipher
);

    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pGAP_WIDTH-1:0] GAP_ONE = {{(pGAP_WIDTH-1){1'b0}}, 1'b1};

    state_e                r_state, w_state_nxt;
    logic [pCNT_WIDTH-1:0] r_count, r_iter;
    logic [pGAP_WIDTH-1:0] r_gap, r_gap_cnt;
    logic                  r_chain, r_done_d, r_start, r_busy, r_batch_done, r_aborted;
    logic [pPT_WIDTH-1:0]  r_textin, r_last_cipher;
    logic [pPT_WIDTH-1:0]  w_next_text, w_seed_text;
    logic [pCNT_WIDTH-1:0] w_iter_inc;
    logic                  w_done_edge, w_go_ok, w_abort_take;

    assign w_done_edge  = I_done & ~r_done_d;
    assign w_go_ok      = batch_go & ~batch_abort;
    assign w_iter_inc   = r_iter + CNT_ONE;
    // FINISH always returns to IDLE, so a held abort cannot trap the FSM there
    assign w_abort_take = batch_abort && (r_state != ST_IDLE) && (r_state != ST_FINISH);

    cw305_aes_batch_sched_textgen #(.pPT_WIDTH(pPT_WIDTH)) u_textgen (
        .i_chain  (r_chain),
        .i_text   (r_textin),
        .i_cipher (I_cipherout),
        .o_next   (w_next_text)
    );

    // Seed selection at batch start
    always_comb begin
        w_seed_text = seed_text;
`ifdef CW305_BATCH_LFSR_EN
        if (!cfg_chain && (seed_text == '0)) begin
            w_seed_text = {{(pPT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_seed_text = seed_text;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go_ok) begin
                    w_state_nxt = (cfg_count == '0) ? ST_FINISH : ST_WAIT_RDY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (batch_abort)  w_state_nxt = ST_FINISH;
                else if (I_ready) w_state_nxt = ST_START;
                else              w_state_nxt = ST_WAIT_RDY;
            end
            ST_START: begin
                if (batch_abort) w_state_nxt = ST_FINISH;
                else             w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_done_edge) begin
                    if (batch_abort || (w_iter_inc == r_count)) w_state_nxt = ST_FINISH;
                    else if (r_gap == '0)                       w_state_nxt = ST_WAIT_RDY;
                    else                                        w_state_nxt = ST_GAP;
                end else if (batch_abort) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (batch_abort)          w_state_nxt = ST_FINISH;
                else if (r_gap_cnt == '0) w_state_nxt = ST_WAIT_RDY;
                else                      w_state_nxt = ST_GAP;
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge crypto_clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_iter        <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_chain       <= 1'b0;
            r_done_d      <= 1'b0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_batch_done  <= 1'b0;
            r_aborted     <= 1'b0;
            r_textin      <= '0;
            r_last_cipher <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_d     <= I_done;
            r_start      <= (w_state_nxt == ST_START);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_batch_done <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (w_go_ok) begin
                        r_count   <= cfg_count;
                        r_gap     <= cfg_gap;
                        r_chain   <= cfg_chain;
                        r_textin  <= w_seed_text;
                        r_iter    <= '0;
                        r_aborted <= 1'b0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_done_edge) begin
                        r_last_cipher <= I_cipherout;
                        r_iter        <= w_iter_inc;
                        r_textin      <= w_next_text;
                        r_gap_cnt     <= r_gap - GAP_ONE;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_ONE;
                end
                default: begin
                end
            endcase
            if (w_abort_take) r_aborted <= 1'b1;
        end
    end

    assign O_start       = r_start;
    assign O_textin      = r_textin;
    assign O_busy        = r_busy;
    assign O_batch_done  = r_batch_done;
    assign O_aborted     = r_aborted;
    assign O_iter        = r_iter;
    assign O_last_cipher = r_last_cipher;

endmodule
